taichip_uart_rx: RTL

Serial byte receiver sitting directly upstream of the taichip core inside tt_um_sohaib_munir_taichip_example.
- Takes the asynchronous UART line from ui_in[0], deserialises 8N1 frames, and presents each byte to the core over a valid/ready handshake.
- Reports framing errors and overruns.
- Reads the same pin the cocotb bench drives, so the bench can feed real serial stimulus.

---
 rtl/taichip_pkg.sv | 17 +
 rtl/taichip_uart_rx_if.sv | 37 +++
 rtl/taichip_sync2.sv | 32 +++
 rtl/taichip_uart_rx.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/taichip_pkg.sv
// rtl/taichip_pkg.sv - shared types and constants for the taichip serial receiver
// Purpose: receiver FSM state encoding and frame geometry, imported by the rx files.
// Ports: none (package).
package taichip_pkg;

    localparam int UART_DATA_BITS = 8;

    // PARITY is declared in every build so encodings never shift with configuration.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/taichip_uart_rx_if.sv
// rtl/taichip_uart_rx_if.sv - byte hand-off bundle between the serial receiver and its consumer
// Purpose: groups the received-byte handshake plus status pulses.
// Ports (master = receiver side):
//   data_o      out  received byte, stable while valid_o=1
//   valid_o     out  byte available
//   ready_i     in   consumer accepts on valid_o & ready_i
//   frame_err_o out  one-cycle pulse, bad stop bit (or parity when enabled)
//   overrun_o   out  one-cycle pulse, byte dropped because holding register was full
//   busy_o      out  frame in progress
interface taichip_uart_rx_if;

    logic [taichip_pkg::UART_DATA_BITS-1:0] data_o;
    logic                                   valid_o;
    logic                                   ready_i;
    logic                                   frame_err_o;
    logic                                   overrun_o;
    logic                                   busy_o;

    modport master (
        output data_o,
        output valid_o,
        input  ready_i,
        output frame_err_o,
        output overrun_o,
        output busy_o
    );

    modport slave (
        input  data_o,
        input  valid_o,
        output ready_i,
        input  frame_err_o,
        input  overrun_o,
        input  busy_o
    );

endinterface

// File: rtl/taichip_sync2.sv
// rtl/taichip_sync2.sv - two-flop synchroniser for an asynchronous input pin
// Purpose: brings one ui_in pin into the clk domain; reusable for any pin.
// Ports:
//   clk  in   destination clock
//   rst  in   asynchronous active-high reset, both flops load RST_VAL
//   i_d  in   asynchronous input
//   o_q  out  synchronised output
module taichip_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_q    <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/taichip_uart_rx.sv
// rtl/taichip_uart_rx.sv - 8N1 serial byte receiver with valid/ready output
// Purpose: deserialises frames on rx_i (idle high), hands each byte to the core,
//          reports framing errors and overruns.
// Configuration: define TAICHIP_RX_PARITY_EN to add an even-parity bit before stop.
// Ports:
//   clk    in   core clock
//   rst    in   asynchronous active-high reset
//   rx_i   in   raw serial line, asynchronous to clk
//   rx_if  master modport: data_o, valid_o, ready_i, frame_err_o, overrun_o, busy_o
module taichip_uart_rx
    import taichip_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    taichip_uart_rx_if.master rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

    logic                      w_rxs;
    rx_state_t                 r_state;
    rx_state_t                 w_next_state;
    logic [CNT_W-1:0]          r_timer;
    logic [CNT_W-1:0]          w_load_val;
    logic                      w_load;
    logic                      w_timer_zero;
    logic [2:0]                r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      w_shift_en;
    logic                      w_par_sample;
    logic                      w_par_err;
    logic                      w_stop_good;
    logic                      w_stop_bad;
    logic [1:0]                r_warm;
    logic                      r_armed;
    logic [UART_DATA_BITS-1:0] r_data;
    logic                      r_valid;
    logic                      r_ferr;
    logic                      r_ovr;

    taichip_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx_i),
        .o_q (w_rxs)
    );

    assign w_timer_zero = (r_timer == '0);

    // The synchroniser's preset 1s are not a real observation of the line, so
    // arming waits until both flops hold sampled data. r_armed then means "the
    // previous rxs was a genuine 1", which makes start detection a true falling
    // edge and ignores a line that is low out of reset or after a bad stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_warm  <= {r_warm[0], 1'b1};
            r_armed <= r_warm[1] & w_rxs;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_shift_en   = 1'b0;
        w_par_sample = 1'b0;
        w_stop_good  = 1'b0;
        w_stop_bad   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_armed && !w_rxs) w_next_state = START;
            end
            START: begin
                if (w_timer_zero) w_next_state = w_rxs ? IDLE : DATA;
            end
            DATA: begin
                if (w_timer_zero) begin
                    w_shift_en = 1'b1;
                    if (r_bit_idx == LAST_IDX) begin
`ifdef TAICHIP_RX_PARITY_EN
                        w_next_state = PARITY;
`else
                        w_next_state = STOP;
`endif
                    end
                end
            end
`ifdef TAICHIP_RX_PARITY_EN
            PARITY: begin
                if (w_timer_zero) begin
                    w_par_sample = 1'b1;
                    w_next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (w_timer_zero) begin
                    w_next_state = IDLE;
                    if (w_rxs && !w_par_err) w_stop_good = 1'b1;
                    else                     w_stop_bad  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Reload on every state change, and between data bits where the state stays DATA.
    assign w_load     = (w_next_state != r_state) || (r_state == DATA && w_timer_zero);
    assign w_load_val = (w_next_state == START) ? HALF_LAST : BIT_LAST;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_load)             r_timer <= w_load_val;
            else if (!w_timer_zero) r_timer <= r_timer - 1'b1;

            if (r_state != DATA)    r_bit_idx <= '0;
            else if (w_shift_en)    r_bit_idx <= r_bit_idx + 1'b1;

            // LSB arrives first, so shift in from the top.
            if (w_shift_en)         r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
        end
    end

`ifdef TAICHIP_RX_PARITY_EN
    logic r_par_err;

    // Even parity: the parity bit equals the XOR of the data bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     r_par_err <= 1'b0;
        else if (r_state == IDLE)                    r_par_err <= 1'b0;
        else if (w_par_sample && (w_rxs != ^r_shift)) r_par_err <= 1'b1;
    end

    assign w_par_err = r_par_err;
`else
    assign w_par_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_ferr <= w_stop_bad;
            r_ovr  <= 1'b0;
            if (w_stop_good) begin
                // An accept in this same cycle frees the register for the new byte.
                if (!r_valid || rx_if.ready_i) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovr <= 1'b1;
                end
            end else if (r_valid && rx_if.ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.data_o      = r_data;
    assign rx_if.valid_o     = r_valid;
    assign rx_if.frame_err_o = r_ferr;
    assign rx_if.overrun_o   = r_ovr;
    assign rx_if.busy_o      = (r_state != IDLE);

endmodule
